// File: rtl/otter_int_pkg.sv
// rtl/otter_int_pkg.sv - shared CSR addresses, trap FSM states and cause constants for the OTTER interrupt controller
package otter_int_pkg;

   localparam logic [11:0] MSTATUS = 12'h300;
   localparam logic [11:0] MIE     = 12'h304;
   localparam logic [11:0] MTVEC   = 12'h305;
   localparam logic [11:0] MEPC    = 12'h341;
   localparam logic [11:0] MCAUSE  = 12'h342;
   localparam logic [11:0] MIP     = 12'h344;

   localparam logic [31:0] MCAUSE_EXT_BASE = 32'h8000_0010;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      TAKE,
      ISR
   } int_state_t;

endpackage

// File: rtl/otter_int_sync.sv
// rtl/otter_int_sync.sv - parameterized-width two-flop synchronizer with async active-low reset
module otter_int_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   // Shift the raw lines through two stages before anyone looks at them.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Both stages clear on reset so no stale request survives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/otter_int_controller.sv
// rtl/otter_int_controller.sv - machine-mode trap sequencer and CSRs; OTTER_INT_VECTORED_EN enables vectored mtvec
module otter_int_controller
   import otter_int_pkg::*;
#(
   parameter int          NUM_SRC     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_SRC-1:0] INT_REQ,
   input  logic               CSR_WE,
   input  logic [11:0]        CSR_ADDR,
   input  logic [31:0]        CSR_WD,
   output logic [31:0]        CSR_RD,
   input  logic               EX_VALID,
   input  logic               STALL,
   input  logic [31:0]        PC_EX,
   input  logic               MRET_EX,
   output logic               INT_TAKEN,
   output logic [31:0]        MTVEC_OUT,
   output logic [31:0]        MEPC_OUT
);

   logic [NUM_SRC-1:0] sync_vec;
   logic [NUM_SRC-1:0] pend;
   logic [3:0]         src;
   logic               csr_wr, take_edge, mret_edge;

   int_state_t         state_q, state_d;
   logic               st_mie_q, st_mie_d;
   logic               st_mpie_q, st_mpie_d;
   logic [NUM_SRC-1:0] mie_q, mie_d;
   logic [31:0]        mtvec_q, mtvec_d;
   logic [31:0]        mepc_q, mepc_d;
   logic [31:0]        mcause_q, mcause_d;
   logic               int_taken_q, int_taken_d;

   otter_int_sync #(.WIDTH(NUM_SRC)) u_sync (
      .clk      (CLK),
      .rst_n    (RST_N),
      .async_in (INT_REQ),
      .sync_out (sync_vec)
   );

   assign pend = sync_vec & mie_q;

   // Lowest pending index wins; scanning downward leaves the smallest one.
   always_comb begin
      src = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i]) src = i[3:0];
      end
   end

   // Next-state for the trap FSM and CSRs; hardware trap/return updates override software writes.
   always_comb begin
      state_d   = state_q;
      st_mie_d  = st_mie_q;
      st_mpie_d = st_mpie_q;
      mie_d     = mie_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;

      csr_wr    = CSR_WE && !STALL;
      take_edge = (state_q == PEND) && (|pend) && st_mie_q && EX_VALID && !STALL && !MRET_EX;
      mret_edge = (state_q == ISR) && MRET_EX && EX_VALID && !STALL;

      case (state_q)
         IDLE: if ((|pend) && st_mie_q) state_d = PEND;
         PEND: begin
            if (!(|pend) || !st_mie_q) state_d = IDLE;
            else if (take_edge)        state_d = TAKE;
         end
         TAKE: state_d = ISR;
         ISR:  if (mret_edge) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (csr_wr) begin
         case (CSR_ADDR)
            MSTATUS: begin
               st_mie_d  = CSR_WD[3];
               st_mpie_d = CSR_WD[7];
            end
            MIE:   mie_d = CSR_WD[NUM_SRC-1:0];
`ifdef OTTER_INT_VECTORED_EN
            MTVEC: mtvec_d = {CSR_WD[31:2], 1'b0, CSR_WD[0]};
`else
            MTVEC: mtvec_d = {CSR_WD[31:2], 2'b00};
`endif
            MEPC:  mepc_d = {CSR_WD[31:2], 2'b00};
            default: ;
         endcase
      end

      if (take_edge) begin
         mepc_d    = PC_EX;
         mcause_d  = MCAUSE_EXT_BASE + {28'b0, src};
         st_mpie_d = st_mie_q;
         st_mie_d  = 1'b0;
      end

      if (mret_edge) begin
         st_mie_d  = st_mpie_q;
         st_mpie_d = 1'b1;
      end

      int_taken_d = (state_d == TAKE);
   end

   // FSM state, CSR storage and the registered trap strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         st_mie_q    <= 1'b0;
         st_mpie_q   <= 1'b0;
         mie_q       <= '0;
         mtvec_q     <= {MTVEC_RESET[31:2], 2'b00};
         mepc_q      <= '0;
         mcause_q    <= '0;
         int_taken_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_mie_q    <= st_mie_d;
         st_mpie_q   <= st_mpie_d;
         mie_q       <= mie_d;
         mtvec_q     <= mtvec_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         int_taken_q <= int_taken_d;
      end
   end

   // Combinational CSR read port; unmapped addresses return zero.
   always_comb begin
      CSR_RD = '0;
      case (CSR_ADDR)
         MSTATUS: CSR_RD = {24'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
         MIE:     CSR_RD = {{(32-NUM_SRC){1'b0}}, mie_q};
         MTVEC:   CSR_RD = mtvec_q;
         MEPC:    CSR_RD = mepc_q;
         MCAUSE:  CSR_RD = mcause_q;
         MIP:     CSR_RD = {{(32-NUM_SRC){1'b0}}, sync_vec};
         default: CSR_RD = '0;
      endcase
   end

`ifdef OTTER_INT_VECTORED_EN
   assign MTVEC_OUT = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {26'b0, mcause_q[3:0], 2'b00} : 32'b0);
`else
   assign MTVEC_OUT = {mtvec_q[31:2], 2'b00};
`endif
   assign MEPC_OUT  = mepc_q;
   assign INT_TAKEN = int_taken_q;

endmodule
